updown_seq_ctrl: RTL and testbench
==================================

Name: updown_seq_ctrl

Overview:
Sequencing controller for the 4-bit up/down/decade counter datapath. On a start pulse it steps the counter through a software-selected subset of its three modes (binary up, binary down, decade up). Each selected mode gets a clear phase followed by a programmable dwell of count cycles. The counter's q is fed back and checked cycle by cycle against an internal expected-value model; a sticky error flag reports any mismatch.

Parameters:
DWELL_W, 8, width of the dwell length input and of the internal dwell counter

Ports:
clk  input  1  system clock, rising edge
clr  input  1  asynchronous active-low reset
start  input  1  one-cycle request; accepted only in IDLE
abort  input  1  synchronous cancel; effective in any state
mode_en  input  3  bit0 = binary up, bit1 = binary down, bit2 = decade; sampled on accepted start
dwell  input  DWELL_W  count cycles per mode; sampled on accepted start; 0 treated as 1
q_in  input  4  counter value feedback
m  output  2  counter mode select: 00 = up, 01 = down, 10 = decade; 11 never driven
cnt_clr  output  1  active-low clear to the counter
busy  output  1  high in CLEAR and RUN
done  output  1  one-cycle completion pulse
err  output  1  sticky feedback-mismatch flag

Behaviour:
- Reset (clr=0, asynchronous): state=IDLE, m=00, cnt_clr=0, busy=0, done=0, err=0. All internal registers are cleared. Reset mid-sequence abandons the sequence immediately.
- All outputs are registered. Every other transition occurs on the rising edge of clk.
- States: IDLE, CLEAR, RUN, DONE.
- IDLE: cnt_clr=0, which holds the counter cleared; m=00; busy=0.
  - start=1 and mode_en!=0: latch mode_en and dwell, select the lowest-index enabled mode, go to CLEAR.
  - start=1 and mode_en=0: go to DONE, which pulses done with no busy cycles.
- CLEAR (1 cycle): m=selected mode code; cnt_clr=0; busy=1.
  - Expected value exp is loaded with 0 for up/decade and 15 for down.
  - Dwell counter is loaded with max(dwell,1).
  - Next state: RUN.
- RUN: cnt_clr=1; busy=1.
  - Each cycle: if q_in != exp, set err.
  - Each cycle: advance exp. Up: exp+1 mod 16. Down: exp-1 mod 16 (0 wraps to 15). Decade: 9 wraps to 0, otherwise +1.
  - Each cycle: decrement the dwell counter.
  - When the dwell counter reaches 1 (last RUN cycle): if a higher-index enabled mode remains, select it and go to CLEAR; otherwise go to DONE.
  - A mode therefore occupies exactly 1 + max(dwell,1) cycles.
- DONE (1 cycle): done=1, busy=0, cnt_clr=0, m=00; next state IDLE.
- abort=1 in CLEAR, RUN or DONE: next state IDLE, no done pulse, err retained. abort takes priority over start and over the dwell terminal transition.
- start outside IDLE is ignored. start and abort both high in IDLE: remain in IDLE.
- err clears only on reset or on an accepted start.
- Decade mode with q_in > 9 is a mismatch. It sets err; exp still follows its own sequence.

Optional Feature:
Macro SEQ_CHECK_EN.
- Defined: the q_in comparison and the err register are built as described.
- Undefined: err is tied to 0, the comparator and exp logic are removed, and q_in is unused. State and timing behaviour are identical.

Test Plan:
1. Reset check: assert clr=0 mid-RUN. Immediately m=00, cnt_clr=0, busy=0, err=0; after release, state is IDLE.
2. Single up mode: mode_en=001, dwell=12, counter model correct. One CLEAR cycle, then 12 RUN cycles with q_in 0..11 and the 16-wrap path exercised by a second run with dwell=20. done pulses once, err=0, busy high for exactly 13 cycles.
3. Full sequence: mode_en=111, dwell=11. m goes 00 → 01 → 10, each preceded by one cnt_clr=0 cycle. Down run observes 15..5; decade run observes 0..9,0. done appears 36 cycles after start; err=0.
4. Mismatch detection: mode_en=100, dwell=5, force q_in=3 on the third RUN cycle (expected 2). err rises the following edge and stays high through DONE and IDLE. The next start clears it.
5. Boundary inputs: dwell=0 with mode_en=010 gives exactly 1 RUN cycle. mode_en=000 with start gives done one cycle later with busy never high. start held during RUN is ignored.
6. Abort: abort=1 in the 4th RUN cycle of mode_en=011. Next cycle IDLE, cnt_clr=0, no done pulse. start and abort high together in IDLE leave the controller in IDLE.

Source files
------------

// File: rtl/updown_seq_ctrl_if.sv
// Control/feedback bundle between updown_seq_ctrl and the counter datapath.
// master = sequencer side, slave = counter/host side.
interface updown_seq_ctrl_if #(
  parameter int DWELL_W = 8
) ();
  logic               start;
  logic               abort;
  logic [2:0]         mode_en;
  logic [DWELL_W-1:0] dwell;
  logic [3:0]         q_in;
  logic [1:0]         m;
  logic               cnt_clr;
  logic               busy;
  logic               done;
  logic               err;

  modport master (
    input  start, abort, mode_en, dwell, q_in,
    output m, cnt_clr, busy, done, err
  );

  modport slave (
    output start, abort, mode_en, dwell, q_in,
    input  m, cnt_clr, busy, done, err
  );
endinterface

// File: rtl/updown_seq_ctrl.sv
// Steps the up/down/decade counter through the enabled modes (clear + dwell each).
// Define SEQ_CHECK_EN to build the q_in feedback checker and sticky err flag.
module updown_seq_ctrl #(
  parameter int DWELL_W = 8
) (
  input  logic              clk,
  input  logic              clr,
  updown_seq_ctrl_if.master sif
);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_DONE} state_t;

  state_t             r_state, w_nstate;
  logic [1:0]         r_sel, w_nsel;
  logic [2:0]         r_men;
  logic [DWELL_W-1:0] r_dwell;
  logic [DWELL_W-1:0] r_dcnt;
  logic [1:0]         r_m;
  logic               r_cnt_clr, r_busy, r_done;
  logic [1:0]         w_first, w_next;
  logic               w_has_next;
  logic               w_start_acc;

  assign w_start_acc = (r_state == S_IDLE) && sif.start && !sif.abort;

  // Mode index doubles as the m code: 0 = up, 1 = down, 2 = decade.
  always_comb begin
    w_first    = 2'd2;
    if (sif.mode_en[0])      w_first = 2'd0;
    else if (sif.mode_en[1]) w_first = 2'd1;
    w_has_next = 1'b0;
    w_next     = r_sel;
    if (r_sel == 2'd0 && r_men[1]) begin
      w_has_next = 1'b1;
      w_next     = 2'd1;
    end else if (r_sel != 2'd2 && r_men[2]) begin
      w_has_next = 1'b1;
      w_next     = 2'd2;
    end
  end

  always_comb begin
    w_nstate = r_state;
    w_nsel   = r_sel;
    unique case (r_state)
      S_IDLE: if (w_start_acc) begin
        if (sif.mode_en != 3'b000) begin
          w_nstate = S_CLEAR;
          w_nsel   = w_first;
        end else begin
          w_nstate = S_DONE;
        end
      end
      S_CLEAR: w_nstate = S_RUN;
      S_RUN: if (r_dcnt == DWELL_W'(1)) begin
        if (w_has_next) begin
          w_nstate = S_CLEAR;
          w_nsel   = w_next;
        end else begin
          w_nstate = S_DONE;
        end
      end
      S_DONE: w_nstate = S_IDLE;
      default: w_nstate = S_IDLE;
    endcase
    if (sif.abort && r_state != S_IDLE) w_nstate = S_IDLE;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state   <= S_IDLE;
      r_sel     <= 2'd0;
      r_men     <= 3'b000;
      r_dwell   <= '0;
      r_dcnt    <= '0;
      r_m       <= 2'd0;
      r_cnt_clr <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_sel   <= w_nsel;
      if (w_start_acc) begin
        r_men   <= sif.mode_en;
        r_dwell <= sif.dwell;
      end
      if (r_state == S_CLEAR)
        r_dcnt <= (r_dwell == '0) ? DWELL_W'(1) : r_dwell;
      else if (r_state == S_RUN)
        r_dcnt <= r_dcnt - DWELL_W'(1);
      // Outputs are decoded from the next state so they line up with it.
      r_m       <= (w_nstate == S_CLEAR || w_nstate == S_RUN) ? w_nsel : 2'd0;
      r_cnt_clr <= (w_nstate == S_RUN);
      r_busy    <= (w_nstate == S_CLEAR || w_nstate == S_RUN);
      r_done    <= (w_nstate == S_DONE);
    end
  end

  assign sif.m       = r_m;
  assign sif.cnt_clr = r_cnt_clr;
  assign sif.busy    = r_busy;
  assign sif.done    = r_done;

`ifdef SEQ_CHECK_EN
  logic [3:0] r_exp;
  logic       r_err;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_exp <= 4'd0;
      r_err <= 1'b0;
    end else begin
      if (w_start_acc)
        r_err <= 1'b0;
      else if (r_state == S_RUN && sif.q_in != r_exp)
        r_err <= 1'b1;
      if (r_state == S_CLEAR) begin
        r_exp <= (r_sel == 2'd1) ? 4'hF : 4'h0;
      end else if (r_state == S_RUN) begin
        unique case (r_sel)
          2'd0:    r_exp <= r_exp + 4'd1;
          2'd1:    r_exp <= r_exp - 4'd1;
          default: r_exp <= (r_exp == 4'd9) ? 4'd0 : r_exp + 4'd1;
        endcase
      end
    end
  end

  assign sif.err = r_err;
`else
  logic w_unused;
  assign w_unused = ^sif.q_in;
  assign sif.err  = 1'b0;
`endif

endmodule

// File: tb/tb_updown_seq_ctrl.sv
// Directed + randomized bench for updown_seq_ctrl against a per-cycle trace model.
module tb_updown_seq_ctrl;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic clr = 1'b0;

  updown_seq_ctrl_if #(.DWELL_W(DW)) sif ();
  updown_seq_ctrl #(.DWELL_W(DW)) dut (.clk(clk), .clr(clr), .sif(sif));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] m;
    logic       cc;
    logic       busy;
    logic       done;
    logic       run;
    logic [3:0] q;
  } rec_t;

  rec_t tr[$];
  int   checks = 0;
  int   errors = 0;
  int   seqn   = 0;
  logic err_m  = 1'b0;

  // Expected cycle-by-cycle picture of one sequence, straight from the mode rules.
  function automatic void build(input logic [2:0] men, input int dw);
    int d;
    rec_t r;
    tr.delete();
    d = (dw == 0) ? 1 : dw;
    for (int k = 0; k < 3; k++) begin
      if (men[k]) begin
        r = '{m: 2'(k), cc: 1'b0, busy: 1'b1, done: 1'b0, run: 1'b0, q: 4'd0};
        tr.push_back(r);
        for (int j = 0; j < d; j++) begin
          r = '{m: 2'(k), cc: 1'b1, busy: 1'b1, done: 1'b0, run: 1'b1, q: 4'd0};
          if (k == 0)      r.q = 4'(j % 16);
          else if (k == 1) r.q = 4'(15 - (j % 16));
          else             r.q = 4'(j % 10);
          tr.push_back(r);
        end
      end
    end
    r = '{m: 2'd0, cc: 1'b0, busy: 1'b0, done: 1'b1, run: 1'b0, q: 4'd0};
    tr.push_back(r);
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [1:0] m, input logic cc,
                         input logic busy, input logic done, input logic err);
    chk({tag, ".m"},    8'(sif.m),       8'(m));
    chk({tag, ".clr"},  8'(sif.cnt_clr), 8'(cc));
    chk({tag, ".busy"}, 8'(sif.busy),    8'(busy));
    chk({tag, ".done"}, 8'(sif.done),    8'(done));
    chk({tag, ".err"},  8'(sif.err),     8'(err));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // action: 0 none, 1 abort at record stop_at, 2 async reset at record stop_at
  task automatic run_seq(input logic [2:0] men, input int dw, input int corrupt,
                         input int stop_at, input int action, input bit hold);
    logic nerr;
    string t;
    seqn++;
    build(men, dw);
    sif.mode_en = men;
    sif.dwell   = DW'(dw);
    sif.abort   = 1'b0;
    sif.start   = 1'b1;
    tick();
    sif.start = 1'b0;
    err_m     = 1'b0;
    for (int i = 0; i < tr.size(); i++) begin
      t = $sformatf("s%0d.c%0d", seqn, i);
      chk_out(t, tr[i].m, tr[i].cc, tr[i].busy, tr[i].done, err_m);
      nerr = err_m;
      sif.q_in = tr[i].run ? ((i == corrupt) ? 4'(tr[i].q + 4'd1) : tr[i].q) : 4'd0;
`ifdef SEQ_CHECK_EN
      if (tr[i].run && i == corrupt) nerr = 1'b1;
`endif
      if (i == stop_at && action == 1) begin
        sif.abort = 1'b1;
        tick();
        sif.abort = 1'b0;
        err_m = nerr;
        chk_out({t, ".abort"}, 2'd0, 1'b0, 1'b0, 1'b0, err_m);
        tick();
        chk_out({t, ".abort+1"}, 2'd0, 1'b0, 1'b0, 1'b0, err_m);
        return;
      end
      if (i == stop_at && action == 2) begin
        #2 clr = 1'b0;
        #1;
        err_m = 1'b0;
        chk_out({t, ".rst"}, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk) clr = 1'b1;
        tick();
        chk_out({t, ".rst_idle"}, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        return;
      end
      sif.start = hold && tr[i].run;
      tick();
      err_m = nerr;
    end
    sif.q_in = 4'd0;
    chk_out($sformatf("s%0d.idle", seqn), 2'd0, 1'b0, 1'b0, 1'b0, err_m);
  endtask

  initial begin
    sif.start   = 1'b0;
    sif.abort   = 1'b0;
    sif.mode_en = 3'b000;
    sif.dwell   = '0;
    sif.q_in    = 4'd0;
    #1;
    chk_out("reset", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk) clr = 1'b1;
    tick();
    chk_out("post_reset", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // single up mode, then the 16-wrap path
    run_seq(3'b001, 12, -1, -1, 0, 1'b0);
    run_seq(3'b001, 20, -1, -1, 0, 1'b0);
    // all three modes back to back
    run_seq(3'b111, 11, -1, -1, 0, 1'b0);
    // decade mismatch on third RUN cycle (record 3), err sticky until next start
    run_seq(3'b100, 5, 3, -1, 0, 1'b0);
    tick();
    chk_out("err_sticky", 2'd0, 1'b0, 1'b0, 1'b0, err_m);
    // boundaries: dwell 0, empty mode set, start held while running
    run_seq(3'b010, 0, -1, -1, 0, 1'b0);
    run_seq(3'b000, 3, -1, -1, 0, 1'b0);
    run_seq(3'b001, 6, -1, -1, 0, 1'b1);
    // abort in the 4th RUN cycle
    run_seq(3'b011, 6, -1, 4, 1, 1'b0);
    sif.mode_en = 3'b001;
    sif.start   = 1'b1;
    sif.abort   = 1'b1;
    tick();
    sif.start = 1'b0;
    sif.abort = 1'b0;
    chk_out("start_abort", 2'd0, 1'b0, 1'b0, 1'b0, err_m);
    tick();
    chk_out("start_abort+1", 2'd0, 1'b0, 1'b0, 1'b0, err_m);
    // async reset mid-RUN after a mismatch has been flagged
    run_seq(3'b011, 10, 2, 5, 2, 1'b0);
    run_seq(3'b110, 4, -1, -1, 0, 1'b0);

    for (int n = 0; n < 12; n++) begin
      logic [2:0] men;
      int dw, cor;
      men = 3'($urandom_range(0, 7));
      dw  = int'($urandom_range(0, 20));
      cor = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 40)) : -1;
      run_seq(men, dw, cor, -1, 0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
